// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - frost32 instruction formats, opcodes and encoder helper types
package instr_encoder_pkg;

    typedef enum logic [2:0] {
        KIND_IOG0    = 3'd0,
        KIND_IOG1    = 3'd1,
        KIND_IOG2    = 3'd2,
        KIND_IOG3    = 3'd3,
        KIND_LDCONST = 3'd4,
        KIND_RSVD5   = 3'd5,
        KIND_RSVD6   = 3'd6,
        KIND_RSVD7   = 3'd7
    } in_kind_t;

    typedef enum logic {
        ST_ACCEPT = 1'b0,
        ST_SECOND = 1'b1
    } enc_state_t;

    typedef enum logic [3:0] {
        Add_ThreeRegs  = 4'd0,
        Sub_ThreeRegs  = 4'd1,
        Sltu_ThreeRegs = 4'd2,
        Slts_ThreeRegs = 4'd3,
        Mul_ThreeRegs  = 4'd4,
        And_ThreeRegs  = 4'd5,
        Orr_ThreeRegs  = 4'd6,
        Xor_ThreeRegs  = 4'd7,
        Nor_ThreeRegs  = 4'd8,
        Lsl_ThreeRegs  = 4'd9,
        Lsr_ThreeRegs  = 4'd10,
        Asr_ThreeRegs  = 4'd11
    } iog0_op_t;

    typedef enum logic [3:0] {
        Addi_TwoRegsOneImm  = 4'd0,
        Subi_TwoRegsOneImm  = 4'd1,
        Sltui_TwoRegsOneImm = 4'd2,
        Sltsi_TwoRegsOneImm = 4'd3,
        Muli_TwoRegsOneImm  = 4'd4,
        Andi_TwoRegsOneImm  = 4'd5,
        Orri_TwoRegsOneImm  = 4'd6,
        Xori_TwoRegsOneImm  = 4'd7,
        Nori_TwoRegsOneImm  = 4'd8,
        Lsli_TwoRegsOneImm  = 4'd9,
        Lsri_TwoRegsOneImm  = 4'd10,
        Asri_TwoRegsOneImm  = 4'd11,
        Sltsi_TwoRegsOneSimm = 4'd12,
        Cpyhi_OneRegOneImm  = 4'd13,
        Bne_TwoRegsOneSimm  = 4'd14,
        Beq_TwoRegsOneSimm  = 4'd15
    } iog1_op_t;

    typedef enum logic [3:0] {
        Jne_ThreeRegs    = 4'd0,
        Jeq_ThreeRegs    = 4'd1,
        Callne_ThreeRegs = 4'd2,
        Calleq_ThreeRegs = 4'd3
    } iog2_op_t;

    typedef enum logic [3:0] {
        Ldr_ThreeRegsLdst  = 4'd0,
        Ldh_ThreeRegsLdst  = 4'd1,
        Ldsh_ThreeRegsLdst = 4'd2,
        Ldb_ThreeRegsLdst  = 4'd3,
        Ldsb_ThreeRegsLdst = 4'd4,
        Str_ThreeRegsLdst  = 4'd5,
        Sth_ThreeRegsLdst  = 4'd6,
        Stb_ThreeRegsLdst  = 4'd7
    } iog3_op_t;

    typedef struct packed {
        logic [3:0]  group;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [3:0]  rc;
        logic [11:0] fill;
        logic [3:0]  opcode;
    } iog0_instr_t;

    typedef struct packed {
        logic [3:0]  group;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [3:0]  opcode;
        logic [15:0] imm;
    } iog1_instr_t;

    typedef iog0_instr_t iog2_instr_t;
    typedef iog0_instr_t iog3_instr_t;

    localparam logic [3:0] IOG1_GROUP = 4'd1;
    localparam iog1_op_t LDCONST_LO_OP = Addi_TwoRegsOneImm;
    localparam iog1_op_t LDCONST_HI_OP = Cpyhi_OneRegOneImm;

    function automatic logic is_bad_op(input logic [2:0] kind, input logic [3:0] opcode);
        logic bad;
        case (kind)
            KIND_IOG0:    bad = (opcode >= 4'd12);
            KIND_IOG1:    bad = 1'b0;
            KIND_IOG2:    bad = (opcode >= 4'd4);
            KIND_IOG3:    bad = (opcode >= 4'd8);
            KIND_LDCONST: bad = 1'b0;
            default:      bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/instr_word_packer.sv
// rtl/instr_word_packer.sv - combinational packing of instruction fields into a frost32 word
module instr_word_packer
    import instr_encoder_pkg::*;
(
    input  logic [3:0]  group,
    input  logic [3:0]  opcode,
    input  logic [3:0]  ra,
    input  logic [3:0]  rb,
    input  logic [3:0]  rc,
    input  logic [15:0] imm,
    output logic [31:0] word
);

    iog0_instr_t reg_fmt;
    iog1_instr_t imm_fmt;

    always_comb begin
        reg_fmt.group  = group;
        reg_fmt.ra     = ra;
        reg_fmt.rb     = rb;
        reg_fmt.rc     = rc;
        reg_fmt.fill   = 12'd0;
        reg_fmt.opcode = opcode;

        imm_fmt.group  = group;
        imm_fmt.ra     = ra;
        imm_fmt.rb     = rb;
        imm_fmt.opcode = opcode;
        imm_fmt.imm    = imm;

        // Iog1 is the only group carrying an immediate; all others share the three-register layout
        word = (group == IOG1_GROUP) ? imm_fmt : reg_fmt;
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - field-level request to frost32 instruction word encoder with LDCONST expansion
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_kind,
    input  logic [3:0]           in_opcode,
    input  logic [3:0]           in_ra,
    input  logic [3:0]           in_rb,
    input  logic [3:0]           in_rc,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic                 out_last,
    output logic                 err_bad_op,
    output logic [CNT_WIDTH-1:0] emit_count
);

    enc_state_t  state, state_next;
    logic [3:0]  hi_ra, hi_ra_next;
    logic [15:0] hi_imm, hi_imm_next;

    logic        in_fire, out_fire, req_bad, req_two;
    logic        load, valid_next, last_next, err_next;
    logic [3:0]  pk_group, pk_op, pk_ra, pk_rb, pk_rc;
    logic [15:0] pk_imm;
    logic [31:0] pk_word;

    instr_word_packer u_packer (
        .group  (pk_group),
        .opcode (pk_op),
        .ra     (pk_ra),
        .rb     (pk_rb),
        .rc     (pk_rc),
        .imm    (pk_imm),
        .word   (pk_word)
    );

    always_comb begin
        in_ready = (state == ST_ACCEPT) && (!out_valid || out_ready);
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        req_bad  = is_bad_op(in_kind, in_opcode);
        req_two  = (in_kind == KIND_LDCONST) && (in_imm[31:16] != 16'd0);

        pk_group = {1'b0, in_kind};
        pk_op    = in_opcode;
        pk_ra    = in_ra;
        pk_rb    = in_rb;
        pk_rc    = in_rc;
        pk_imm   = in_imm[15:0];
        if (state == ST_SECOND) begin
            pk_group = IOG1_GROUP;
            pk_op    = LDCONST_HI_OP;
            pk_ra    = hi_ra;
            pk_rb    = 4'd0;
            pk_rc    = 4'd0;
            pk_imm   = hi_imm;
        end else if (in_kind == KIND_LDCONST) begin
            pk_group = IOG1_GROUP;
            pk_op    = LDCONST_LO_OP;
            pk_rb    = 4'd0;
            pk_rc    = 4'd0;
        end
    end

    always_comb begin
        state_next  = state;
        hi_ra_next  = hi_ra;
        hi_imm_next = hi_imm;
        load        = 1'b0;
        valid_next  = out_valid && !out_ready;
        last_next   = out_last;
        err_next    = 1'b0;

        case (state)
            ST_ACCEPT: begin
                if (in_fire) begin
                    if (req_bad) begin
                        err_next = 1'b1;
                    end else begin
                        load       = 1'b1;
                        valid_next = 1'b1;
                        last_next  = !req_two;
                        if (req_two) begin
                            state_next  = ST_SECOND;
                            hi_ra_next  = in_ra;
                            hi_imm_next = in_imm[31:16];
                        end
                    end
                end
            end
            ST_SECOND: begin
                // Cpyhi replaces the Addi word in the same cycle the Addi is handed off
                if (out_fire) begin
                    load        = 1'b1;
                    valid_next  = 1'b1;
                    last_next   = 1'b1;
                    state_next  = ST_ACCEPT;
                    hi_ra_next  = 4'd0;
                    hi_imm_next = 16'd0;
                end
            end
            default: state_next = ST_ACCEPT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_ACCEPT;
            hi_ra      <= 4'd0;
            hi_imm     <= 16'd0;
            out_valid  <= 1'b0;
            out_instr  <= 32'd0;
            out_last   <= 1'b0;
            err_bad_op <= 1'b0;
            emit_count <= '0;
        end else begin
            state      <= state_next;
            hi_ra      <= hi_ra_next;
            hi_imm     <= hi_imm_next;
            out_valid  <= valid_next;
            out_last   <= last_next;
            err_bad_op <= err_next;
            if (load) begin
                out_instr <= pk_word;
            end
            if (out_fire) begin
                emit_count <= emit_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule
